// File: rtl/pipeline_monitor_pkg.sv
// Shared state encoding, counter indices and saturating arithmetic for the
// pipeline performance monitor.
package pipeline_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } monState_t;

  localparam logic [3:0] CNT_CYCLES  = 4'd0;
  localparam logic [3:0] CNT_RETIRED = 4'd1;
  localparam logic [3:0] CNT_STALL   = 4'd2;
  localparam logic [3:0] CNT_FLUSH   = 4'd3;
  localparam logic [3:0] CNT_EVT0    = 4'd4;

  // Callers zero-extend into this width, so counters up to 64 bits are supported.
  localparam int SAT_MAX_W = 64;

  function automatic logic [SAT_MAX_W-1:0] satInc(
    input logic [SAT_MAX_W-1:0] value,
    input logic [SAT_MAX_W-1:0] maxValue,
    input logic                 inc
  );
    if (inc && (value != maxValue)) begin
      return value + 64'd1;
    end
    return value;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// First-word-fall-through FIFO for retired-instruction trace entries.
// i_reset is asynchronous and active-low; i_clear empties it synchronously.
module trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clear,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [AW:0]      r_count;
  logic             w_doPush;
  logic             w_doPop;

  assign o_empty  = (r_count == '0);
  assign o_full   = (r_count == FULL_CNT);
  assign w_doPop  = i_pop && !o_empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_doPush = i_push && (!o_full || w_doPop);
  assign o_data   = o_empty ? '0 : r_mem[r_rdPtr];

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_doPush) r_mem[r_wrPtr] <= i_data;
  end

endmodule

// File: rtl/pipeline_perf_monitor.sv
// Saturating event counters, retirement trace FIFO and end-of-program drain
// sequencer for the pipelined CPU. i_reset is asynchronous and active-low.
module pipeline_perf_monitor #(
  parameter int CNT_W        = 32,
  parameter int NUM_EVT      = 4,
  parameter int TRACE_DEPTH  = 8,
  parameter int PC_W         = 32,
  parameter int INSTR_W      = 32,
  parameter int DRAIN_CYCLES = 5
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic               i_clear,
  input  logic               i_wb_valid,
  input  logic [PC_W-1:0]    i_wb_pc,
  input  logic [INSTR_W-1:0] i_wb_instr,
  input  logic               i_stall,
  input  logic               i_flush,
  input  logic [NUM_EVT-1:0] i_evt,
  input  logic               i_end_program,
  input  logic [3:0]         i_cnt_sel,
  output logic [CNT_W-1:0]   o_cnt_out,
  output logic               o_trace_valid,
  input  logic               i_trace_ready,
  output logic [PC_W-1:0]    o_trace_pc,
  output logic [INSTR_W-1:0] o_trace_instr,
  output logic [CNT_W-1:0]   o_trace_cycle,
  output logic               o_trace_overflow,
  output logic               o_done,
  output logic [1:0]         o_state
);

  import pipeline_monitor_pkg::*;

  localparam int NUM_CNT = 4 + NUM_EVT;
  localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);
  localparam int ENTRY_W = PC_W + INSTR_W + CNT_W;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

  monState_t          r_state;
  monState_t          w_nextState;
  logic [DRAIN_W-1:0] r_drainCnt;
  logic               r_done;
  logic [CNT_W-1:0]   r_cnt [NUM_CNT];
  logic [CNT_W-1:0]   r_cntOut;
  logic [CNT_W-1:0]   w_cntMux;
  logic [NUM_CNT-1:0] w_evtVec;
  logic               r_overflow;
  logic               w_active;
  logic               w_push;
  logic               w_pop;
  logic               w_fifoFull;
  logic               w_fifoEmpty;
  logic [ENTRY_W-1:0] w_headData;

  assign w_active = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  // Bit order follows the counter map: cycles, retired, stall, flush, evt[0..].
  assign w_evtVec = {i_evt, i_flush, i_stall, i_wb_valid, 1'b1};

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE:  if (i_enable) w_nextState = ST_RUN;
      ST_RUN: begin
        if (i_end_program)  w_nextState = ST_DRAIN;
        else if (!i_enable) w_nextState = ST_IDLE;
      end
      ST_DRAIN: if (r_drainCnt == DRAIN_LAST) w_nextState = ST_DONE;
      ST_DONE:  w_nextState = ST_DONE;
      default:  w_nextState = ST_IDLE;
    endcase
    if (i_clear) w_nextState = ST_IDLE;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state    <= ST_IDLE;
      r_drainCnt <= '0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_done     <= (w_nextState == ST_DONE);
      r_drainCnt <= (!i_clear && r_state == ST_DRAIN) ? r_drainCnt + 1'b1 : '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < NUM_CNT; i++) r_cnt[i] <= '0;
    end else if (i_clear) begin
      for (int i = 0; i < NUM_CNT; i++) r_cnt[i] <= '0;
    end else if (w_active) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        r_cnt[i] <= CNT_W'(satInc(SAT_MAX_W'(r_cnt[i]),
                                  SAT_MAX_W'({CNT_W{1'b1}}),
                                  w_evtVec[i]));
      end
    end
  end

  always_comb begin
    w_cntMux = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (i_cnt_sel == 4'(i)) w_cntMux = r_cnt[i];
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_cntOut <= '0;
    else          r_cntOut <= w_cntMux;
  end

  assign w_pop  = !w_fifoEmpty && i_trace_ready;
  assign w_push = w_active && i_wb_valid && !i_clear;

  // Overflow only when the entry is truly lost: full and nothing leaving.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset)                              r_overflow <= 1'b0;
    else if (i_clear)                          r_overflow <= 1'b0;
    else if (w_push && w_fifoFull && !w_pop)   r_overflow <= 1'b1;
  end

  trace_fifo #(
    .WIDTH(ENTRY_W),
    .DEPTH(TRACE_DEPTH)
  ) u_traceFifo (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_clear(i_clear),
    .i_push (w_push),
    .i_data ({i_wb_pc, i_wb_instr, r_cnt[CNT_CYCLES]}),
    .i_pop  (w_pop),
    .o_data (w_headData),
    .o_full (w_fifoFull),
    .o_empty(w_fifoEmpty)
  );

  assign {o_trace_pc, o_trace_instr, o_trace_cycle} = w_headData;
  assign o_trace_valid    = !w_fifoEmpty;
  assign o_trace_overflow = r_overflow;
  assign o_cnt_out        = r_cntOut;
  assign o_done           = r_done;
  assign o_state          = r_state;

endmodule

// File: tb/tb_pipeline_perf_monitor.sv
// Directed bench for pipeline_perf_monitor: counter reads are checked inline,
// trace entries through a scoreboard queue popped by a monitor process.
module tb_pipeline_perf_monitor;

  localparam int CNT_W = 8;
  localparam int NUM_EVT = 4;
  localparam int TRACE_DEPTH = 4;
  localparam int PC_W = 32;
  localparam int INSTR_W = 32;
  localparam int DRAIN_CYCLES = 5;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [7:0]  cyc;
  } traceExp_t;

  logic               clk = 1'b0;
  logic               rstN;
  logic               enable, clear, wbValid, stall, flush, endProgram, traceReady;
  logic [PC_W-1:0]    wbPc;
  logic [INSTR_W-1:0] wbInstr;
  logic [NUM_EVT-1:0] evt;
  logic [3:0]         cntSel;
  logic [CNT_W-1:0]   cntOut;
  logic               traceValid, traceOverflow, done;
  logic [PC_W-1:0]    tracePc;
  logic [INSTR_W-1:0] traceInstr;
  logic [CNT_W-1:0]   traceCycle;
  logic [1:0]         state;

  int        checks = 0;
  int        errors = 0;
  traceExp_t sbQ[$];
  traceExp_t monExp;

  always #5 clk = ~clk;

  pipeline_perf_monitor #(
    .CNT_W(CNT_W), .NUM_EVT(NUM_EVT), .TRACE_DEPTH(TRACE_DEPTH),
    .PC_W(PC_W), .INSTR_W(INSTR_W), .DRAIN_CYCLES(DRAIN_CYCLES)
  ) dut (
    .i_clk(clk), .i_reset(rstN), .i_enable(enable), .i_clear(clear),
    .i_wb_valid(wbValid), .i_wb_pc(wbPc), .i_wb_instr(wbInstr),
    .i_stall(stall), .i_flush(flush), .i_evt(evt), .i_end_program(endProgram),
    .i_cnt_sel(cntSel), .o_cnt_out(cntOut), .o_trace_valid(traceValid),
    .i_trace_ready(traceReady), .o_trace_pc(tracePc), .o_trace_instr(traceInstr),
    .o_trace_cycle(traceCycle), .o_trace_overflow(traceOverflow),
    .o_done(done), .o_state(state)
  );

  function automatic logic [31:0] instrOf(input logic [31:0] pc);
    return {16'hC0DE, pc[15:0]};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] pc,
                               input logic st, input logic fl, input logic [3:0] ev);
    wbValid = v;
    wbPc    = pc;
    wbInstr = instrOf(pc);
    stall   = st;
    flush   = fl;
    evt     = ev;
  endtask

  task automatic expectTrace(input logic [31:0] pc, input logic [7:0] cyc);
    traceExp_t e;
    e.pc    = pc;
    e.instr = instrOf(pc);
    e.cyc   = cyc;
    sbQ.push_back(e);
  endtask

  task automatic readCnt(input logic [3:0] sel, input logic [31:0] expected,
                         input string name);
    cntSel = sel;
    step(1);
    checkOutput(name, 32'(cntOut), expected);
  endtask

  // Scoreboard monitor: every accepted head is compared against the queue front.
  always @(negedge clk) begin
    if (rstN && traceValid && traceReady) begin
      if (sbQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL trace_unexpected actual_pc=0x%0h expected=none", tracePc);
      end else begin
        monExp = sbQ.pop_front();
        checkOutput("trace_pc", tracePc, monExp.pc);
        checkOutput("trace_instr", traceInstr, monExp.instr);
        checkOutput("trace_cycle", 32'(traceCycle), 32'(monExp.cyc));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rstN = 1'b0; enable = 0; clear = 0; endProgram = 0; traceReady = 0; cntSel = 0;
    applyStimulus(0, 32'h0, 0, 0, 4'h0);
    #12;
    checkOutput("rst_state", 32'(state), 0);
    checkOutput("rst_done", 32'(done), 0);
    checkOutput("rst_trace_valid", 32'(traceValid), 0);
    checkOutput("rst_overflow", 32'(traceOverflow), 0);
    checkOutput("rst_cnt_out", 32'(cntOut), 0);
    checkOutput("rst_trace_pc", tracePc, 0);
    rstN = 1'b1;
    step(1);

    // Ten idle-event cycles; ready while empty must be harmless
    traceReady = 1; enable = 1;
    step(1);
    checkOutput("run_state", 32'(state), 1);
    checkOutput("ready_empty", 32'(traceValid), 0);
    traceReady = 0;
    step(9);
    enable = 0;
    step(1);
    checkOutput("idle_state", 32'(state), 0);
    readCnt(4'd0, 10, "cycles_10");
    for (int s = 1; s < 8; s++) readCnt(4'(s), 0, "cnt_zero");
    readCnt(4'd8, 0, "sel_oob8");
    readCnt(4'd15, 0, "sel_oob15");

    // Six retirements into a depth-4 FIFO with no consumer
    clear = 1; step(1); clear = 0;
    enable = 1; step(1);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 32'(i * 4), 0, 0, 4'h0);
      if (i < 4) expectTrace(32'(i * 4), 8'(i));
      step(1);
    end
    applyStimulus(0, 32'h0, 0, 0, 4'h0);
    enable = 0;
    step(1);
    checkOutput("ovf_set", 32'(traceOverflow), 1);
    checkOutput("ovf_valid", 32'(traceValid), 1);
    checkOutput("ovf_head_pc", tracePc, 32'h0);
    readCnt(4'd1, 6, "retired_6");
    readCnt(4'd0, 7, "cycles_7");
    traceReady = 1; step(4); traceReady = 0;
    checkOutput("ovf_drained", 32'(traceValid), 0);
    checkOutput("ovf_sticky", 32'(traceOverflow), 1);
    checkOutput("sb_empty_1", 32'(sbQ.size()), 0);

    // Full FIFO with simultaneous push and pop
    clear = 1; step(1); clear = 0;
    checkOutput("clear_ovf", 32'(traceOverflow), 0);
    enable = 1; step(1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 32'h100 + 32'(i * 4), 0, 0, 4'h0);
      expectTrace(32'h100 + 32'(i * 4), 8'(i));
      step(1);
    end
    applyStimulus(1, 32'h110, 0, 0, 4'h0);
    traceReady = 1;
    expectTrace(32'h110, 8'd4);
    step(1);
    applyStimulus(0, 32'h0, 0, 0, 4'h0);
    traceReady = 0; enable = 0;
    step(1);
    checkOutput("pp_no_ovf", 32'(traceOverflow), 0);
    checkOutput("pp_head_pc", tracePc, 32'h104);
    readCnt(4'd1, 5, "retired_5");
    traceReady = 1; step(4); traceReady = 0;
    checkOutput("pp_drained", 32'(traceValid), 0);
    checkOutput("sb_empty_2", 32'(sbQ.size()), 0);

    // End-of-program drain with enable dropped on the same cycle
    clear = 1; step(1); clear = 0;
    enable = 1; step(1);
    applyStimulus(1, 32'h200, 1, 0, 4'b0101);
    expectTrace(32'h200, 8'd0);
    step(1);
    applyStimulus(0, 32'h0, 1, 0, 4'b0101);
    step(1);
    applyStimulus(0, 32'h0, 0, 1, 4'b0101);
    step(1);
    applyStimulus(0, 32'h0, 0, 0, 4'h0);
    step(17);
    endProgram = 1; enable = 0;
    step(1);
    endProgram = 0;
    checkOutput("drain_state", 32'(state), 2);
    checkOutput("drain_done0", 32'(done), 0);
    step(4);
    checkOutput("drain_state4", 32'(state), 2);
    checkOutput("drain_done4", 32'(done), 0);
    step(1);
    checkOutput("done_state", 32'(state), 3);
    checkOutput("done_set", 32'(done), 1);
    step(3);
    checkOutput("done_hold", 32'(state), 3);
    readCnt(4'd0, 26, "cycles_26");
    readCnt(4'd1, 1, "drain_retired");
    readCnt(4'd2, 2, "drain_stall");
    readCnt(4'd3, 1, "drain_flush");
    readCnt(4'd4, 3, "evt0");
    readCnt(4'd5, 0, "evt1");
    readCnt(4'd6, 3, "evt2");
    readCnt(4'd7, 0, "evt3");
    readCnt(4'd0, 26, "cycles_hold");
    traceReady = 1; step(1); traceReady = 0;
    checkOutput("done_popped", 32'(traceValid), 0);

    // Clear in DRAIN beats a simultaneous retirement and events
    clear = 1; step(1); clear = 0;
    checkOutput("clr_idle", 32'(state), 0);
    checkOutput("clr_done", 32'(done), 0);
    enable = 1; step(1);
    applyStimulus(1, 32'h300, 0, 0, 4'h0);
    step(1);
    applyStimulus(0, 32'h0, 0, 0, 4'h0);
    endProgram = 1; step(1); endProgram = 0;
    checkOutput("pre_clr_drain", 32'(state), 2);
    clear = 1;
    applyStimulus(1, 32'h304, 1, 0, 4'hF);
    step(1);
    clear = 0; enable = 0;
    applyStimulus(0, 32'h0, 0, 0, 4'h0);
    checkOutput("clr_drain_state", 32'(state), 0);
    checkOutput("clr_drain_valid", 32'(traceValid), 0);
    checkOutput("clr_drain_ovf", 32'(traceOverflow), 0);
    for (int s = 0; s < 8; s++) readCnt(4'(s), 0, "clr_cnt");

    // Saturation of 8-bit counters
    enable = 1; step(1);
    applyStimulus(0, 32'h0, 1, 0, 4'b0010);
    step(270);
    applyStimulus(0, 32'h0, 0, 0, 4'h0);
    enable = 0; step(1);
    readCnt(4'd2, 255, "stall_sat");
    readCnt(4'd0, 255, "cycles_sat");
    readCnt(4'd5, 255, "evt1_sat");
    readCnt(4'd4, 0, "evt0_after_sat");

    // Asynchronous reset mid-RUN
    clear = 1; step(1); clear = 0;
    enable = 1; step(1);
    applyStimulus(1, 32'h400, 0, 0, 4'h0);
    step(1);
    applyStimulus(0, 32'h0, 0, 0, 4'h0);
    cntSel = 0; step(2);
    checkOutput("pre_rst_valid", 32'(traceValid), 1);
    #2 rstN = 1'b0;
    #1;
    checkOutput("arst_state", 32'(state), 0);
    checkOutput("arst_valid", 32'(traceValid), 0);
    checkOutput("arst_pc", tracePc, 0);
    checkOutput("arst_cycle", 32'(traceCycle), 0);
    checkOutput("arst_cnt_out", 32'(cntOut), 0);
    checkOutput("arst_done", 32'(done), 0);
    enable = 0;
    #3 rstN = 1'b1;
    step(2);

    checkOutput("sb_leftover", 32'(sbQ.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_perf_monitor.md
# pipeline_perf_monitor

Synthesizable performance and trace monitor for the pipelined CPU. It replaces the simulation-only per-cycle display logic with hardware:
- saturating event counters for cycles, retired instructions, stalls, flushes and NUM_EVT generic events;
- a valid/ready trace FIFO of retired instructions;
- an end-of-program drain sequence.

It sits beside `cpu_pipelined`, tapping WB-stage and hazard/forwarding signals, and is read by a debug host or bench.

## Interface
- CNT_W, 32: width of every counter and of trace_cycle
- NUM_EVT, 4: number of generic event inputs (e.g. forwardA!=0, forwardB!=0, branch taken, mispredict); 1..8
- TRACE_DEPTH, 8: trace FIFO entries; power of two, ≥2
- PC_W, 32 / INSTR_W, 32: trace field widths
- DRAIN_CYCLES, 5: cycles counted after end_program before done
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low (asserted at 0)
- enable  in  1  run control
- clear  in  1  synchronous clear of counters, overflow, FIFO and FSM
- wb_valid  in  1  instruction retires this cycle
- wb_pc  in  PC_W  PC of retiring instruction
- wb_instr  in  INSTR_W  retiring instruction word
- stall  in  1  pipeline stall this cycle
- flush  in  1  pipeline flush this cycle
- evt  in  NUM_EVT  generic event strobes, one per bit
- end_program  in  1  program-end indication
- cnt_sel  in  4  counter index for readout
- cnt_out  out  CNT_W  registered counter value
- trace_valid  out  1  FIFO head valid
- trace_ready  in  1  consumer accepts head
- trace_pc  out  PC_W  head PC
- trace_instr  out  INSTR_W  head instruction
- trace_cycle  out  CNT_W  cycle-counter value at capture
- trace_overflow  out  1  sticky: a retirement was dropped
- done  out  1  drain complete
- state  out  2  FSM state, for debug

## Operation
- FSM states: IDLE=0, RUN=1, DRAIN=2, DONE=3.
  - IDLE→RUN when enable=1.
  - RUN→IDLE when enable=0; counters hold.
  - RUN→DRAIN on end_program=1; this has priority over enable=0.
  - DRAIN→DONE after exactly DRAIN_CYCLES cycles in DRAIN; enable is ignored in DRAIN.
  - DONE holds until clear or reset.
- clear=1 in any state: next state IDLE, all counters 0, FIFO emptied, overflow 0. clear beats every simultaneous event.
- Counting is active in RUN and DRAIN only.
- Counter map:
  - 0: cycles (+1 every active cycle)
  - 1: retired (wb_valid)
  - 2: stall
  - 3: flush
  - 4..4+NUM_EVT-1: evt[i]
- Each counter saturates at 2^CNT_W−1; it never wraps.
- cnt_sel out of range gives cnt_out=0.
- Trace capture:
  - On wb_valid in an active state, push {wb_pc, wb_instr, current cycles value (pre-increment)}.
  - Full FIFO and no pop in the same cycle: the entry is dropped and trace_overflow set (sticky until clear). The retired counter still increments.
  - Full FIFO with push and pop in the same cycle: both happen, occupancy is unchanged, no overflow.
  - Pop when trace_valid && trace_ready; pointers wrap modulo TRACE_DEPTH.
  - Ready while empty is a no-op.
- Pops are accepted in every state, including IDLE and DONE, so the FIFO can be drained after done.

## Timing
- Reset values: cnt_out=0, trace_valid=0, trace_pc/instr/cycle=0, trace_overflow=0, done=0, state=IDLE. All counters and FIFO pointers are 0.
- Counter updates land at the rising edge ending the event cycle.
- cnt_out has 1-cycle latency. cnt_sel sampled at edge k shows the counter value held before edge k.
- Trace: wb_valid captured at edge k into an empty FIFO gives trace_valid=1 after edge k (first-word fall-through from storage). Head outputs are stable while trace_valid && !trace_ready.
- done rises at the edge entering DONE and is registered.
- Reset asserted mid-operation returns all state to reset values immediately. The FIFO contents are lost.

## Structure
- Package `pipeline_monitor_pkg` holds:
  - the state encoding constants;
  - the counter-index constants (CNT_CYCLES=0, CNT_RETIRED=1, CNT_STALL=2, CNT_FLUSH=3, CNT_EVT0=4);
  - a saturating-increment function.
- One sub-module, `trace_fifo`, is parametrised on width and depth, with push/pop/full/empty and FWFT output. The top handles the FSM, counters and readout mux.

## Test plan
- Reset, enable=1, run 10 cycles with no events → cnt_sel=0 reads 10. cnt_sel=1..7 read 0. state=RUN.
- CNT_W=4: hold stall=1 for 20 active cycles → the stall counter reads 15 (saturated, not 4).
- TRACE_DEPTH=4, trace_ready=0, 6 consecutive retirements (PCs 0x0..0x14) → 4 entries held, trace_overflow=1, retired=6. Then ready=1 → pops 0x0,0x4,0x8,0xC with trace_cycle 0,1,2,3.
- Full FIFO with a simultaneous push and pop → occupancy stays 4, overflow stays 0, the new PC appears after the remaining entries.
- end_program pulse at cycle 20 with enable dropped the same cycle → DRAIN. done=1 exactly 5 cycles later. The cycles counter reads 26 and holds. The FIFO is still poppable.
- clear asserted together with wb_valid and evt=4'hF in DRAIN → next cycle IDLE, all counters 0, trace_valid=0, overflow 0. Then asserting reset at 0 mid-RUN immediately zeroes all outputs.
